fp_mult_sequencer: RTL and testbench
====================================

// Module: fp_mult_sequencer
// PURPOSE
//  Control FSM for the multi-cycle single-precision floating-point multiply datapath.
//  Accepts an operand pair with a valid/ready handshake and drives the datapath strobes:
//  operand load, multiply enable, normalise, round, result load.
//  Short-circuits special operands (NaN/Inf/zero) and exponent overflow/underflow.
//  Presents the result with a valid/ready handshake.
//  Sits between the issuing requester and the floating_multiplier datapath.
// PARAMETERS
//  MUL_CYCLES  2  cycles the significand multiplier needs (>=1); mul_en held this many cycles
//  EXP_W       8  exponent field width
// PORTS
//  CLK          in   1      single clock, rising edge
//  RST          in   1      synchronous, active-high reset
//  in_valid     in   1      requester presents operands a,b to the datapath
//  in_ready     out  1      sequencer can accept operands
//  out_valid    out  1      result register c holds a finished product
//  out_ready    in   1      consumer takes result
//  a_exp        in   EXP_W  exponent of registered operand a
//  b_exp        in   EXP_W  exponent of registered operand b
//  a_frac_nz    in   1      |significand of registered operand a
//  b_frac_nz    in   1      |significand of registered operand b
//  product_msb  in   1      multiplier product overflowed into bit 1.x (needs >>1)
//  round_carry  in   1      rounding carried out of the significand
//  exp_ovf      in   1      datapath exponent above 8'hFE
//  exp_unf      in   1      datapath exponent below 1
//  loadInReg    out  1      load operand registers
//  mul_en       out  1      multiplier active
//  norm_shift   out  1      shift significand right 1, exponent +1
//  round_en     out  1      apply round-to-nearest-even
//  loadOutReg   out  1      load result register
//  special_sel  out  2      00 normal, 01 zero, 10 inf, 11 qNaN; muxes result field
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  - RST (any state, overrides all) -> IDLE, counter=0, special_sel=00.
//  - During RST, every output is 0, including in_ready.
//  - in_ready = (state==IDLE) & ~RST.
//  - loadInReg = in_valid & in_ready (combinational; operands captured on the accept edge).
//  - States and transitions:
//    IDLE  -> CLASS on accept.
//    CLASS -> WRITE if special, else MULT.
//    MULT  -> NORM after MUL_CYCLES cycles (counter 0..MUL_CYCLES-1).
//    NORM  -> ROUND.
//    ROUND -> RENORM if round_carry, else WRITE.
//    RENORM -> WRITE.
//    WRITE -> DONE.
//    DONE  -> IDLE when out_ready.
//  - CLASS priority: NaN (either exp=FF with frac_nz, or Inf x zero) -> 11; Inf -> 10;
//    zero (exp=0; denormals flush to zero) -> 01. special_sel is registered at CLASS exit.
//  - MULT: mul_en=1 in every MULT cycle. NORM: norm_shift=product_msb (NORM state is always taken).
//  - ROUND: round_en=1. RENORM: norm_shift=1.
//  - On exit of ROUND/RENORM with special_sel==00: exp_ovf -> 10, else exp_unf -> 01.
//  - WRITE: loadOutReg=1 for one cycle.
//  - DONE: out_valid=1, held stable until out_ready. Sign of the result comes from the datapath XOR.
//  - Latency from accept cycle 0: normal out_valid at cycle 5+MUL_CYCLES; +1 with RENORM.
//    Special operands: out_valid at cycle 3.
//  - Back-pressure: no new accept while DONE. out_ready & in_valid in the same DONE cycle ->
//    IDLE next cycle, accept no earlier than that cycle (no bypass).
//  - Strobes are mutually exclusive, one-hot per state.
// STRUCTURE
//  - Shared include fp_mult_defs.vh holds: state encodings, special_sel codes (SEL_NONE/ZERO/INF/NAN),
//    EXP_W=8, FRAC_W=23, EXP_ALL1=8'hFF.
//  - One combinational sub-module fp_operand_class(exp, frac_nz -> is_zero, is_inf, is_nan).
//    Instantiated twice.
//  - FSM, MULT counter and special_sel register live in this module.
// TESTING (MUL_CYCLES=2)
//  - 1.5 x 2.0: accept cyc0 -> mul_en cyc2-3, round_en cyc5, loadOutReg cyc6, out_valid cyc7,
//    special_sel=00.
//  - a_exp=FF, a_frac_nz=1 -> special_sel=11, out_valid cyc3, mul_en never asserted.
//    Inf x zero gives the same result.
//  - round_carry=1 in ROUND -> norm_shift pulse cyc6, loadOutReg cyc7, out_valid cyc8.
//  - exp_ovf=1 at ROUND exit -> special_sel=10; exp_unf alone -> 01.
//  - out_ready low 5 cycles in DONE -> out_valid and in_ready=0 held; out_ready=1 -> IDLE,
//    in_ready=1 next cycle.
//  - RST pulse during MULT -> next cycle IDLE, all strobes 0, special_sel=00.
//    The following operation completes with normal latency.

Source files
------------

// File: rtl/fp_mult_sequencer_pkg.sv
// Shared constants, state encoding and special-result codes
// for the floating-point multiply sequencer.
package fp_mult_sequencer_pkg;

   localparam int EXP_W = 8;
   localparam int FRAC_W = 23;
   localparam logic [7:0] EXP_ALL1 = 8'hFF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLASS,
      S_MULT,
      S_NORM,
      S_ROUND,
      S_RENORM,
      S_WRITE,
      S_DONE
   } state_e;

   typedef enum logic [1:0] {
      SEL_NONE = 2'b00,
      SEL_ZERO = 2'b01,
      SEL_INF  = 2'b10,
      SEL_NAN  = 2'b11
   } sel_e;

endpackage

// File: rtl/fp_operand_class.sv
// Classifies one operand from its exponent and significand-nonzero flag.
// Denormals (exponent 0) are treated as zero.
module fp_operand_class
   import fp_mult_sequencer_pkg::*;
#(
   parameter int EW = EXP_W
) (
   input  logic [EW-1:0] exp_i,
   input  logic          frac_nz_i,
   output logic          is_zero_o,
   output logic          is_inf_o,
   output logic          is_nan_o
);

   logic exp_max;

   assign exp_max   = (exp_i == {EW{1'b1}});
   assign is_zero_o = (exp_i == '0);
   assign is_inf_o  = exp_max & ~frac_nz_i;
   assign is_nan_o  = exp_max & frac_nz_i;

endmodule

// File: rtl/fp_mult_sequencer.sv
// Control FSM for the multi-cycle single-precision multiply datapath:
// operand handshake, datapath strobes, special-case and range override.
module fp_mult_sequencer
   import fp_mult_sequencer_pkg::*;
#(
   parameter int MUL_CYCLES = 2,
   parameter int EXP_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic [EXP_W-1:0] a_exp,
   input  logic [EXP_W-1:0] b_exp,
   input  logic             a_frac_nz,
   input  logic             b_frac_nz,
   input  logic             product_msb,
   input  logic             round_carry,
   input  logic             exp_ovf,
   input  logic             exp_unf,
   output logic             loadInReg,
   output logic             mul_en,
   output logic             norm_shift,
   output logic             round_en,
   output logic             loadOutReg,
   output logic [1:0]       special_sel,
   output logic             busy
);

   localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

   state_e           state_q, state_d;
   sel_e             sel_q, sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic a_zero, a_inf, a_nan;
   logic b_zero, b_inf, b_nan;
   sel_e cls_sel, rng_sel;

   logic mul_c, norm_c, round_c, ldout_c;

   fp_operand_class #(.EW(EXP_W)) u_cls_a (
      .exp_i     (a_exp),
      .frac_nz_i (a_frac_nz),
      .is_zero_o (a_zero),
      .is_inf_o  (a_inf),
      .is_nan_o  (a_nan)
   );

   fp_operand_class #(.EW(EXP_W)) u_cls_b (
      .exp_i     (b_exp),
      .frac_nz_i (b_frac_nz),
      .is_zero_o (b_zero),
      .is_inf_o  (b_inf),
      .is_nan_o  (b_nan)
   );

   // Inf x zero is an invalid operation and yields NaN
   always_comb begin
      cls_sel = SEL_NONE;
      if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero))
         cls_sel = SEL_NAN;
      else if (a_inf | b_inf)
         cls_sel = SEL_INF;
      else if (a_zero | b_zero)
         cls_sel = SEL_ZERO;
   end

   always_comb begin
      rng_sel = sel_q;
      if (sel_q == SEL_NONE) begin
         if (exp_ovf)
            rng_sel = SEL_INF;
         else if (exp_unf)
            rng_sel = SEL_ZERO;
      end
   end

   assign in_ready  = (state_q == S_IDLE) & ~RST;
   assign loadInReg = in_valid & in_ready;

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      mul_c   = 1'b0;
      norm_c  = 1'b0;
      round_c = 1'b0;
      ldout_c = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (loadInReg)
               state_d = S_CLASS;
         end
         S_CLASS: begin
            sel_d   = cls_sel;
            cnt_d   = '0;
            state_d = (cls_sel != SEL_NONE) ? S_WRITE : S_MULT;
         end
         S_MULT: begin
            mul_c = 1'b1;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = S_NORM;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_NORM: begin
            norm_c  = product_msb;
            state_d = S_ROUND;
         end
         S_ROUND: begin
            round_c = 1'b1;
            if (round_carry) begin
               state_d = S_RENORM;
            end else begin
               state_d = S_WRITE;
               sel_d   = rng_sel;
            end
         end
         S_RENORM: begin
            norm_c  = 1'b1;
            state_d = S_WRITE;
            sel_d   = rng_sel;
         end
         S_WRITE: begin
            ldout_c = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (out_ready)
               state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         sel_q   <= SEL_NONE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
      end
   end

   // Reset forces every output low, even mid-operation
   assign mul_en      = mul_c & ~RST;
   assign norm_shift  = norm_c & ~RST;
   assign round_en    = round_c & ~RST;
   assign loadOutReg  = ldout_c & ~RST;
   assign out_valid   = (state_q == S_DONE) & ~RST;
   assign busy        = (state_q != S_IDLE) & ~RST;
   assign special_sel = RST ? 2'b00 : sel_q;

endmodule

// File: tb/tb_fp_mult_sequencer.sv
// Randomised scoreboard bench for fp_mult_sequencer (MUL_CYCLES=2).
module tb_fp_mult_sequencer;

   localparam int MC = 2;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] a_exp = '0;
   logic [7:0] b_exp = '0;
   logic       a_frac_nz = 1'b0;
   logic       b_frac_nz = 1'b0;
   logic       product_msb = 1'b0;
   logic       round_carry = 1'b0;
   logic       exp_ovf = 1'b0;
   logic       exp_unf = 1'b0;
   logic       in_ready, out_valid, loadInReg, mul_en;
   logic       norm_shift, round_en, loadOutReg, busy;
   logic [1:0] special_sel;

   fp_mult_sequencer #(.MUL_CYCLES(MC), .EXP_W(8)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .a_exp       (a_exp),
      .b_exp       (b_exp),
      .a_frac_nz   (a_frac_nz),
      .b_frac_nz   (b_frac_nz),
      .product_msb (product_msb),
      .round_carry (round_carry),
      .exp_ovf     (exp_ovf),
      .exp_unf     (exp_unf),
      .loadInReg   (loadInReg),
      .mul_en      (mul_en),
      .norm_shift  (norm_shift),
      .round_en    (round_en),
      .loadOutReg  (loadOutReg),
      .special_sel (special_sel),
      .busy        (busy)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] ae;
      logic [7:0] be;
      bit anz, bnz, pm, rc, ovf, unf;
   } txn_t;

   typedef struct {
      int sel, lat, nmul, nnorm, nround, nload;
   } exp_t;

   exp_t sb[$];
   int   compared = 0;
   int   failed = 0;
   int   stall_cfg = -1;

   task automatic chk(input string nm, input int act, input int req);
      compared++;
      if (act != req) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   function automatic exp_t model(input txn_t t);
      exp_t e;
      bit az, ai, an, bz, bi, bn, spec;
      az = (t.ae == 8'd0);
      ai = (t.ae == 8'd255) && !t.anz;
      an = (t.ae == 8'd255) && t.anz;
      bz = (t.be == 8'd0);
      bi = (t.be == 8'd255) && !t.bnz;
      bn = (t.be == 8'd255) && t.bnz;
      spec = az | ai | an | bz | bi | bn;
      if (an || bn || (ai && bz) || (bi && az)) e.sel = 3;
      else if (ai || bi) e.sel = 2;
      else if (az || bz) e.sel = 1;
      else if (t.ovf) e.sel = 2;
      else if (t.unf) e.sel = 1;
      else e.sel = 0;
      e.nload = 1;
      if (spec) begin
         e.lat = 3;
         e.nmul = 0;
         e.nnorm = 0;
         e.nround = 0;
      end else begin
         e.lat = 5 + MC + int'(t.rc);
         e.nmul = MC;
         e.nnorm = int'(t.pm) + int'(t.rc);
         e.nround = 1;
      end
      return e;
   endfunction

   task automatic drive(input txn_t t);
      a_exp = t.ae;
      b_exp = t.be;
      a_frac_nz = t.anz;
      b_frac_nz = t.bnz;
      product_msb = t.pm;
      round_carry = t.rc;
      exp_ovf = t.ovf;
      exp_unf = t.unf;
   endtask

   task automatic accept(input txn_t t, input bit push, output bit ok);
      int n = 0;
      @(negedge CLK);
      drive(t);
      in_valid = 1'b1;
      #1;
      while (!loadInReg && n < 60) begin
         @(negedge CLK);
         #1;
         n++;
      end
      ok = loadInReg;
      if (!ok) chk("accept_timeout", n, 0);
      else if (push) sb.push_back(model(t));
      @(posedge CLK);
      #1 in_valid = 1'b0;
   endtask

   task automatic send(input txn_t t);
      bit ok;
      int n = 0;
      accept(t, 1'b1, ok);
      if (ok) begin
         while (!out_valid && n < 60) begin
            @(negedge CLK);
            n++;
         end
         if (!out_valid) chk("done_timeout", n, 0);
      end
   endtask

   function automatic txn_t mk(input int ae, input bit anz,
                               input int be, input bit bnz,
                               input bit pm, input bit rc,
                               input bit ovf, input bit unf);
      txn_t t;
      t.ae = 8'(ae);
      t.be = 8'(be);
      t.anz = anz;
      t.bnz = bnz;
      t.pm = pm;
      t.rc = rc;
      t.ovf = ovf;
      t.unf = unf;
      return t;
   endfunction

   function automatic logic [7:0] rnd_exp();
      int k = $urandom_range(0, 5);
      if (k == 0) return 8'd0;
      if (k == 1) return 8'd255;
      return 8'($urandom_range(1, 254));
   endfunction

   // Monitor: tracks each operation from its accept cycle to the output handshake
   initial begin
      bit active = 0, seen = 0, chk_idle = 0, bad = 0;
      int cyc = 0, nmul = 0, nnorm = 0, nround = 0, nload = 0;
      int lat = 0, stall_left = 0;
      logic [1:0] sel0 = '0;
      exp_t e;
      forever begin
         @(negedge CLK);
         #2;
         if (RST) begin
            active = 0;
            seen = 0;
            chk_idle = 0;
         end else begin
            if (chk_idle) begin
               chk("idle_after_done", int'(in_ready), 1);
               chk_idle = 0;
            end
            if (!active && loadInReg) begin
               active = 1;
               cyc = -1;
               nmul = 0;
               nnorm = 0;
               nround = 0;
               nload = 0;
               bad = 0;
            end
            if (active) begin
               cyc++;
               if ($countones({loadInReg, mul_en, norm_shift,
                               round_en, loadOutReg}) > 1) bad = 1;
               if (cyc > 0 && loadInReg) bad = 1;
               nmul += int'(mul_en);
               nnorm += int'(norm_shift);
               nround += int'(round_en);
               nload += int'(loadOutReg);
               if (!seen && out_valid) begin
                  seen = 1;
                  lat = cyc;
                  sel0 = special_sel;
                  stall_left = (stall_cfg >= 0) ? stall_cfg
                                                : $urandom_range(0, 3);
               end else if (seen) begin
                  if (!out_valid || special_sel != sel0) bad = 1;
               end
               if (seen && in_ready) bad = 1;
               if (seen) begin
                  if (stall_left > 0) begin
                     out_ready = 1'b0;
                     stall_left--;
                  end else begin
                     out_ready = 1'b1;
                     if (sb.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                     end else begin
                        e = sb.pop_front();
                        chk("latency", lat, e.lat);
                        chk("special_sel", int'(sel0), e.sel);
                        chk("mul_en_cycles", nmul, e.nmul);
                        chk("norm_shift_cycles", nnorm, e.nnorm);
                        chk("round_en_cycles", nround, e.nround);
                        chk("loadOutReg_cycles", nload, e.nload);
                        chk("protocol", int'(bad), 0);
                     end
                     active = 0;
                     seen = 0;
                     chk_idle = 1;
                  end
               end else begin
                  out_ready = 1'($urandom_range(0, 1));
                  if (cyc > 40) begin
                     chk("output_timeout", cyc, 0);
                     active = 0;
                     if (sb.size() > 0) void'(sb.pop_front());
                  end
               end
            end else begin
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      end
   end

   initial begin
      txn_t t;
      bit ok;
      int n;
      RST = 1'b1;
      in_valid = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      chk("rst_outputs", int'({in_ready, out_valid, loadInReg, mul_en,
                              norm_shift, round_en, loadOutReg, busy,
                              special_sel}), 0);
      @(negedge CLK);
      in_valid = 1'b0;
      RST = 1'b0;
      #1;
      chk("rst_release", int'({in_ready, busy, special_sel}), 4'b1000);

      send(mk(127, 1, 128, 0, 0, 0, 0, 0));
      send(mk(255, 1, 100, 0, 0, 0, 0, 0));
      send(mk(255, 0, 0, 0, 0, 0, 0, 0));
      send(mk(120, 1, 130, 1, 1, 1, 0, 0));
      send(mk(200, 0, 200, 1, 1, 0, 1, 0));
      send(mk(3, 1, 4, 0, 0, 0, 0, 1));
      send(mk(100, 0, 255, 0, 0, 0, 0, 0));
      send(mk(0, 1, 90, 1, 0, 0, 0, 0));
      stall_cfg = 5;
      send(mk(127, 0, 127, 0, 0, 0, 0, 0));
      stall_cfg = -1;

      for (int i = 0; i < 150; i++) begin
         t.ae = rnd_exp();
         t.be = rnd_exp();
         t.anz = 1'($urandom_range(0, 1));
         t.bnz = 1'($urandom_range(0, 1));
         t.pm = 1'($urandom_range(0, 1));
         t.rc = 1'($urandom_range(0, 1));
         t.ovf = ($urandom_range(0, 3) == 0);
         t.unf = ($urandom_range(0, 3) == 0);
         send(t);
      end

      accept(mk(127, 1, 127, 1, 1, 1, 0, 0), 1'b0, ok);
      if (ok) begin
         @(posedge CLK);
         #1;
         chk("mult_before_rst", int'(mul_en), 1);
         RST = 1'b1;
         #1;
         chk("rst_mid_outputs", int'({in_ready, out_valid, loadInReg,
                                     mul_en, norm_shift, round_en,
                                     loadOutReg, busy, special_sel}), 0);
         @(posedge CLK);
         #1 RST = 1'b0;
         #1;
         chk("after_rst", int'({in_ready, busy, special_sel, mul_en,
                               norm_shift, round_en, loadOutReg}),
             8'b1000_0000);
      end
      send(mk(127, 1, 128, 0, 1, 0, 0, 0));

      n = 0;
      while (sb.size() > 0 && n < 200) begin
         @(negedge CLK);
         n++;
      end
      chk("scoreboard_drained", sb.size(), 0);
      repeat (3) @(negedge CLK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, failed);
      $finish;
   end

endmodule
